// File: rtl/nn_pkg.sv
// Shared Q8.8 fixed-point definitions for the neural datapath blocks.
// Holds the saturation helper and the weighted_sum state encoding.
package nn_pkg;

    localparam int FRAC = 8;
    localparam logic signed [15:0] Q_MAX = 16'sh7FFF;
    localparam logic signed [15:0] Q_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        ST_IN  = 2'd0,
        ST_ARG = 2'd1,
        ST_ERR = 2'd2,
        ST_UPD = 2'd3
    } ws_state_t;

    // Clamp any wide signed intermediate into the Q8.8 range.
    function automatic logic signed [15:0] sat16(input logic signed [47:0] v);
        if (v > 48'sd32767) begin
            return Q_MAX;
        end else if (v < -48'sd32768) begin
            return Q_MIN;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage

// File: rtl/weighted_sum_if.sv
// Strobe/ready handshakes around weighted_sum: activation input,
// sum output towards the sigmoid unit, and its error feedback.
interface weighted_sum_if;
    logic               inp_stb;
    logic [7:0]         inp_dat;
    logic               inp_rdy;
    logic               arg_stb;
    logic signed [15:0] arg_dat;
    logic               arg_rdy;
    logic               err_stb;
    logic signed [15:0] err_dat;
    logic               err_rdy;

    modport slave (
        input  inp_stb, inp_dat, arg_rdy, err_stb, err_dat,
        output inp_rdy, arg_stb, arg_dat, err_rdy
    );

    modport master (
        output inp_stb, inp_dat, arg_rdy, err_stb, err_dat,
        input  inp_rdy, arg_stb, arg_dat, err_rdy
    );
endinterface

// File: rtl/weighted_sum_ram.sv
// N x 16 signed weight store: async clear, combinational read, one write port.
module weight_ram #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic signed [15:0]      rd_dat,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic signed [15:0]      wr_dat
);

    logic signed [15:0] mem [N];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/weighted_sum.sv
// Dot product of N Q0.8 activations with trainable Q8.8 weights, feeding
// a sigmoid unit and applying its returned error as a shift-scaled update.
module weighted_sum
    import nn_pkg::*;
#(
    parameter int N    = 4,
    parameter int RATE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    weighted_sum_if.slave    bus
);

    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    ws_state_t          st;
    logic [IDX_W-1:0]   idx;
    logic signed [31:0] acc;
    logic               trn;
    logic signed [15:0] e;
    logic [7:0]         x [N];

    logic signed [15:0] w_rd;
    logic signed [15:0] w_new;
    logic               w_we;
    logic signed [24:0] mac_prod;
    logic signed [31:0] acc_nxt;
    logic signed [47:0] arg_wide;
    logic signed [24:0] upd_prod;
    logic signed [24:0] upd_step;
    logic signed [47:0] w_wide;

    // Both the MAC and the update walk the weights with idx, so one read port suffices.
    weight_ram #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .rd_idx (idx),
        .rd_dat (w_rd),
        .wr_en  (w_we),
        .wr_idx (idx),
        .wr_dat (w_new)
    );

    always_comb begin
        mac_prod = $signed({1'b0, bus.inp_dat}) * w_rd;
        acc_nxt  = acc + 32'(mac_prod);
        arg_wide = 48'(acc_nxt >>> FRAC);
        upd_prod = e * $signed({1'b0, x[idx]});
        upd_step = upd_prod >>> (FRAC + RATE);
        w_wide   = 48'(w_rd) + 48'(upd_step);
        w_new    = sat16(w_wide);
    end

    assign bus.inp_rdy = (st == ST_IN) && rst;
    assign bus.err_rdy = (st == ST_ERR);
    assign w_we        = (st == ST_UPD) && trn;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st          <= ST_IN;
            idx         <= '0;
            acc         <= '0;
            trn         <= 1'b0;
            e           <= '0;
            bus.arg_stb <= 1'b0;
            bus.arg_dat <= '0;
            for (int i = 0; i < N; i++) begin
                x[i] <= '0;
            end
        end else begin
            case (st)
                ST_IN: begin
                    if (bus.inp_stb) begin
                        x[idx] <= bus.inp_dat;
                        acc    <= acc_nxt;
                        if (idx == IDX_LAST) begin
                            st          <= ST_ARG;
                            idx         <= '0;
                            bus.arg_stb <= 1'b1;
                            bus.arg_dat <= sat16(arg_wide);
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_ARG: begin
                    // en only matters at the instant the sum is taken.
                    if (bus.arg_rdy) begin
                        bus.arg_stb <= 1'b0;
                        acc         <= '0;
                        trn         <= en;
                        st          <= en ? ST_ERR : ST_IN;
                    end
                end
                ST_ERR: begin
                    if (bus.err_stb) begin
                        e   <= bus.err_dat;
                        st  <= ST_UPD;
                        idx <= '0;
                    end
                end
                ST_UPD: begin
                    if (idx == IDX_LAST) begin
                        st  <= ST_IN;
                        idx <= '0;
                        trn <= 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    st <= ST_IN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weighted_sum.sv
// Directed bench for weighted_sum: inference, training, saturation,
// backpressure, late enable and asynchronous reset aborts.
module tb_weighted_sum;

    localparam int N = 4;

    logic clk;
    logic rst;
    logic en;
    int   checks;
    int   errors;

    weighted_sum_if bus ();

    weighted_sum #(
        .N    (N),
        .RATE (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] wt(input int i);
        return dut.u_ram.mem[i];
    endfunction

    task automatic push(input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        bus.inp_stb = 1'b1;
        bus.inp_dat = d;
        while (!bus.inp_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("inp_timeout", {15'b0, bus.inp_rdy}, 16'd1);
        @(posedge clk);
        #1 bus.inp_stb = 1'b0;
    endtask

    task automatic feed(input logic [7:0] a, b, c, d, input logic [15:0] exp, input bit chk,
                        input string tag);
        push(a);
        push(b);
        push(c);
        push(d);
        if (chk) begin
            check({tag, "_stb"}, {15'b0, bus.arg_stb}, 16'd1);
            check({tag, "_dat"}, bus.arg_dat, exp);
        end
    endtask

    task automatic ack_arg();
        @(negedge clk);
        bus.arg_rdy = 1'b1;
        @(posedge clk);
        #1 bus.arg_rdy = 1'b0;
    endtask

    task automatic err_ack(input logic [15:0] ev);
        int n;
        n = 0;
        @(negedge clk);
        bus.err_stb = 1'b1;
        bus.err_dat = ev;
        while (!bus.err_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("err_timeout", {15'b0, bus.err_rdy}, 16'd1);
        @(posedge clk);
        #1 bus.err_stb = 1'b0;
    endtask

    task automatic pass(input logic [7:0] a, b, c, d, input logic en_v, input logic [15:0] ev,
                        input logic [15:0] exp, input bit chk, input string tag);
        en = en_v;
        feed(a, b, c, d, exp, chk, tag);
        ack_arg();
        if (en_v) begin
            err_ack(ev);
            repeat (N) @(posedge clk);
            #1;
        end
        en = 1'b0;
    endtask

    // Pull reset low between clock edges so only the async path can act.
    task automatic async_rst_low();
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
    endtask

    task automatic rst_release();
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        en          = 1'b0;
        bus.inp_stb = 1'b0;
        bus.inp_dat = '0;
        bus.arg_rdy = 1'b0;
        bus.err_stb = 1'b0;
        bus.err_dat = '0;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_arg_stb", {15'b0, bus.arg_stb}, 16'd0);
        check("rst_arg_dat", bus.arg_dat, 16'h0000);
        check("rst_err_rdy", {15'b0, bus.err_rdy}, 16'd0);
        check("rst_w0", wt(0), 16'h0000);
        rst_release();
        check("rel_inp_rdy", {15'b0, bus.inp_rdy}, 16'd1);

        // Zero weights give a zero sum; no training round-trip without en.
        pass(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 16'h0, 16'h0000, 1'b1, "t1");
        check("t1_arg_dropped", {15'b0, bus.arg_stb}, 16'd0);
        check("t1_inp_rdy", {15'b0, bus.inp_rdy}, 16'd1);
        check("t1_err_rdy", {15'b0, bus.err_rdy}, 16'd0);

        // 0x1000 * 0x80 >>> 12 = 0x80 into w0 only.
        pass(8'h80, 8'h00, 8'h00, 8'h00, 1'b1, 16'h1000, 16'h0000, 1'b1, "t2a");
        check("t2_inp_rdy", {15'b0, bus.inp_rdy}, 16'd1);
        check("t2_w0", wt(0), 16'h0080);
        for (int i = 1; i < N; i++) check($sformatf("t2_w%0d", i), wt(i), 16'h0000);
        pass(8'h80, 8'h00, 8'h00, 8'h00, 1'b0, 16'h0, 16'h0040, 1'b1, "t2b");

        // Raising en after the acknowledge must not start a training round.
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        check("t5_err_rdy", {15'b0, bus.err_rdy}, 16'd0);
        check("t5_inp_rdy", {15'b0, bus.inp_rdy}, 16'd1);
        en = 1'b0;
        check("t5_w0", wt(0), 16'h0080);

        // Backpressure with stray input strobes.
        feed(8'h80, 8'h00, 8'h00, 8'h00, 16'h0040, 1'b1, "t4");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.inp_stb = 1'b1;
            bus.inp_dat = 8'hFF;
            check($sformatf("t4_hold_stb%0d", k), {15'b0, bus.arg_stb}, 16'd1);
            check($sformatf("t4_hold_dat%0d", k), bus.arg_dat, 16'h0040);
            check($sformatf("t4_hold_rdy%0d", k), {15'b0, bus.inp_rdy}, 16'd0);
            @(posedge clk);
        end
        @(negedge clk);
        bus.inp_stb = 1'b0;
        ack_arg();
        check("t4_after_stb", {15'b0, bus.arg_stb}, 16'd0);
        check("t4_after_rdy", {15'b0, bus.inp_rdy}, 16'd1);
        pass(8'h80, 8'h00, 8'h00, 8'h00, 1'b0, 16'h0, 16'h0040, 1'b1, "t4b");

        async_rst_low();
        check("t3_clear_w0", wt(0), 16'h0000);
        rst_release();

        // 0x7FFF * 0xFF >>> 12 = 2039 per pass; 17 passes saturate.
        for (int k = 0; k < 17; k++) begin
            pass(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 16'h7FFF, 16'h0000, k == 0, "t3p");
            if (k == 0) check("t3_w0_p1", wt(0), 16'h07F7);
            if (k == 15) check("t3_w1_p16", wt(1), 16'h7F70);
        end
        for (int i = 0; i < N; i++) check($sformatf("t3_wmax%0d", i), wt(i), 16'h7FFF);

        // 0x8000 * 0xFF >>> 12 = -2040 per pass; 33 passes reach the floor.
        for (int k = 0; k < 33; k++) begin
            pass(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 16'h8000, 16'h7FFF, k == 0, "t3n");
            if (k == 15) check("t3_w3_n16", wt(3), 16'h007F);
        end
        for (int i = 0; i < N; i++) check($sformatf("t3_wmin%0d", i), wt(i), 16'h8000);
        pass(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 16'h0, 16'h8000, 1'b1, "t3min");

        // Reset in the middle of the update walk (idx == 2).
        en = 1'b1;
        feed(8'hFF, 8'hFF, 8'hFF, 8'hFF, 16'h8000, 1'b1, "t6u");
        ack_arg();
        en = 1'b0;
        err_ack(16'h1000);
        repeat (2) @(posedge clk);
        #1;
        check("t6_w0_upd", wt(0), 16'h80FF);
        check("t6_w2_pending", wt(2), 16'h8000);
        async_rst_low();
        for (int i = 0; i < N; i++) check($sformatf("t6_upd_w%0d", i), wt(i), 16'h0000);
        check("t6_upd_err_rdy", {15'b0, bus.err_rdy}, 16'd0);
        rst_release();
        check("t6_upd_inp_rdy", {15'b0, bus.inp_rdy}, 16'd1);

        // Reset while a nonzero sum is waiting to be taken.
        pass(8'h80, 8'h00, 8'h00, 8'h00, 1'b1, 16'h1000, 16'h0000, 1'b1, "t6t");
        feed(8'h80, 8'h00, 8'h00, 8'h00, 16'h0040, 1'b1, "t6a");
        async_rst_low();
        check("t6_arg_stb", {15'b0, bus.arg_stb}, 16'd0);
        check("t6_arg_dat", bus.arg_dat, 16'h0000);
        check("t6_arg_w0", wt(0), 16'h0000);
        rst_release();
        pass(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 16'h0, 16'h0000, 1'b1, "t6f");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/weighted_sum.md
Name: weighted_sum

Overview:
- Upstream initiator for the sigmoid activation unit.
- Accepts N unsigned Q0.8 activations one at a time and accumulates their dot product with N internal signed Q8.8 weights.
- Drives the saturated Q8.8 sum on the arg interface.
- In training (en=1), accepts the Q8.8 error returned by the activation unit's feedback port and applies a shift-scaled, saturating weight update.

Parameters:
N, 4, number of inputs/weights per evaluation (2..64)
RATE, 4, learning-rate right shift; update = (err*x) >>> (8+RATE)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low; clears all state while low
en  input  1  training enable, sampled on arg acknowledge
inp_stb  input  1  input activation valid
inp_dat  input  8  unsigned Q0.8 activation
inp_rdy  output  1  input accepted when inp_stb & inp_rdy
arg_stb  output  1  weighted sum valid (to activation arg port)
arg_dat  output  16  signed Q8.8 saturated sum
arg_rdy  input  1  downstream accepts arg
err_stb  input  1  error valid (from activation feedback port)
err_dat  input  16  signed Q8.8 error
err_rdy  output  1  error accepted when err_stb & err_rdy

Behaviour:
- Reset (rst low, async):
  - st=IN, idx=0, acc=0, all weights=0, stored inputs=0, trn=0.
  - arg_stb=0, arg_dat=0; inp_rdy=1 once released; err_rdy=0.
- Acknowledge is stb & rdy on every interface. Data is sampled only on acknowledge.
- States: IN, ARG, ERR, UPD. Illegal encoding returns to IN.
- IN:
  - inp_rdy=1.
  - Each inp ack: x[idx] <= inp_dat; acc <= acc + $signed({1'b0,inp_dat}) * w[idx]. acc is 32-bit signed; the 9x16 product is sign-extended.
  - idx increments on each ack.
  - On the ack with idx==N-1, all at the same edge: st<=ARG, arg_stb<=1, arg_dat<=sat16(acc_next>>>8), idx<=0.
  - Latency: arg_stb is high the cycle after the last input ack.
- ARG:
  - arg_stb and arg_dat are held stable until arg ack; inp_rdy=0.
  - On arg ack: arg_stb<=0, acc<=0, trn<=en. Next state is ERR if en, else IN.
  - arg_stb never goes low without an ack.
- ERR:
  - err_rdy=1 (combinational from state).
  - On err ack: e<=err_dat, st<=UPD, idx<=0.
  - Nothing else is accepted.
- UPD:
  - One weight per cycle, N cycles: w[idx] <= sat16(w[idx] + ((e * $signed({1'b0,x[idx]})) >>> (8+RATE))).
  - Arithmetic shift truncates toward -inf.
  - After idx==N-1: st<=IN, idx<=0, trn<=0. All rdy outputs are 0 during UPD.
- sat16: clamp a wide signed value to [-32768, 32767] (0x8000..0x7FFF).
- Weights persist across evaluations and are cleared only by reset.
- en changes outside the arg acknowledge cycle have no effect on the current evaluation.
- Only one interface is ready per state, so simultaneous strobes on inp and err cannot both be accepted.
- Reset mid-operation (any state) aborts immediately: a pending arg is dropped, arg_stb falls asynchronously, and weights are zeroed.

Decomposition:
- Shared package (nn_pkg):
  - Q8.8 constants FRAC=8, Q_MAX=16'sh7FFF, Q_MIN=16'sh8000.
  - sat16 function.
  - State localparams/enum for this block.
- One natural sub-module, weight_ram: N x 16 register array with async clear, one combinational read port (idx) and one write port.
- MAC and update datapaths stay in weighted_sum.

Test Plan:
1. Reset, en=0, four inputs 0xFF -> arg_stb high the cycle after the 4th ack, arg_dat=0x0000; after ack, st=IN, err_rdy never asserted.
2. en=1, inputs {0x80,0,0,0}, arg ack, err_dat=0x1000 -> after 4 UPD cycles w0=0x0080, w1..3=0. Next evaluation with same inputs -> arg_dat=0x0040.
3. Weight saturation, en=1, inputs all 0xFF, err_dat=0x7FFF:
   - Each pass adds 2039 to every weight.
   - After 17 passes all weights = 0x7FFF (never wrap).
   - Then inputs all 0xFF -> arg_dat=0x7FFF (acc>>>8 = 130556 clamped).
   - Repeat with err_dat=0x8000 -> weights clamp to 0x8000, arg_dat=0x8000.
4. Backpressure: hold arg_rdy=0 for 5 cycles -> arg_stb=1 and arg_dat constant throughout, inp_rdy=0, extra inp_stb ignored; ack on cycle 6 -> state advances.
5. en toggled to 1 one cycle after arg ack with en=0 -> no ERR state; weights unchanged on next evaluation.
6. Assert rst low during UPD (idx=2) and during ARG with arg_stb=1 -> outputs/weights cleared asynchronously without a clock edge. After release, a fresh 4-input evaluation yields arg_dat=0.
